strobe_monitor: RTL and testbench
=================================

Name: strobe_monitor

Overview:
- Receiving-end counterpart of the strobe generator: measures the interval between rising edges of an incoming strobe in Clock cycles.
- Compares each interval against the expected period derived from CLOCK_HZ/PERIOD_NS and flags early, late and missing strobes.
- Reports lock after a run of in-tolerance periods.
- Sits downstream of any periodic tick source (strobe generator, external PPS already synchronised to Clock) as a health/supervision block.

Parameters:
- CLOCK_HZ, 10_000_000, Clock frequency in Hz (real allowed).
- PERIOD_NS, 1000, expected strobe period in ns.
- TOLERANCE, 1, allowed deviation in ticks either side of TICKS.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert Locked_o.
- Localparams, not overridable:
  - TICKS = round(CLOCK_HZ*PERIOD_NS/1e9), minimum 2.
  - TIMEOUT = 2*TICKS.
  - WIDTH = clog2(TIMEOUT+1).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Enable_i  input  1  1 = monitor running; 0 = idle.
- Strobe_i  input  1  strobe, synchronous to Clock, any high width.
- Period_o  output  WIDTH  last measured interval in Clock cycles.
- Valid_o  output  1  one-cycle pulse: new Period_o and flags are valid.
- Ok_o  output  1  last period within TICKS±TOLERANCE (valid with Valid_o, held).
- Early_o  output  1  last period < TICKS-TOLERANCE (held).
- Late_o  output  1  last period > TICKS+TOLERANCE (held).
- Timeout_o  output  1  one-cycle pulse: no edge within TIMEOUT cycles.
- Locked_o  output  1  level: LOCK_COUNT consecutive Ok periods seen.

Behaviour:
- Reset (Reset=0, async): all outputs 0; state IDLE; counter, lock counter, Strobe_q = 0.
- Edge detect:
  - Strobe_q <= Strobe_i every cycle, including IDLE.
  - edge = Strobe_i & ~Strobe_q, so a multi-cycle high counts once.
- State machine:
  - IDLE: counter held 0.
    - Enable_i=1 -> ARMED.
  - ARMED: waits for the first edge.
    - edge -> counter <= 1, MEASURE; no Valid_o.
  - MEASURE: counter increments every cycle without an edge.
    - On edge (cycle M, previous edge cycle N): Period_o <= counter (= M-N), Valid_o pulses in cycle M+1, flags updated, counter <= 1, stay MEASURE.
    - Else if counter == TIMEOUT: Timeout_o pulses next cycle, Locked_o <= 0, lock counter <= 0, -> ARMED. Period_o and flags unchanged.
  - Any state, Enable_i=0: -> IDLE next cycle. Counter and lock counter cleared; Locked_o <= 0; Period_o and flags hold; no Valid_o/Timeout_o.
- Classification (exactly one of Ok/Early/Late set after the first measurement):
  - Early if Period < TICKS-TOLERANCE.
  - Late if Period > TICKS+TOLERANCE.
  - Ok otherwise; boundaries TICKS±TOLERANCE are Ok.
- Lock:
  - Ok period: lock counter increments, saturating at LOCK_COUNT.
  - Locked_o rises in the same cycle as the Valid_o that brings the count to LOCK_COUNT.
  - Early/Late period: lock counter <= 0 and Locked_o <= 0, in the same cycle as Valid_o.
- Simultaneous events:
  - Edge when counter == TIMEOUT: the edge wins. Period = TIMEOUT, Late, no Timeout_o.
  - Edge in the cycle Enable_i drops: ignored, go to IDLE.
- Counter never exceeds TIMEOUT, so there is no wrap-around.
- Reset asserted mid-measurement: outputs clear immediately, asynchronously.

Test Plan (CLOCK_HZ=11_000_000, PERIOD_NS=1000 -> TICKS=11, TIMEOUT=22, TOLERANCE=1, LOCK_COUNT=4):
- Lock-up: release Reset, Enable_i=1, 1-cycle strobes every 11 cycles ×6.
  - First edge: no Valid_o.
  - Each later edge: Valid_o one cycle after, Period_o=11, Ok_o=1.
  - Locked_o=1 with the 4th Valid_o.
- Tolerance boundaries: intervals 10, 12, 13, 9.
  - 10 and 12 -> Ok_o.
  - 13 -> Late_o, Locked_o=0.
  - 9 -> Early_o.
  - Lock counter restarts: 4 further 11s are needed to relock.
- Wide pulses: strobe held high 5 cycles, rising edges 11 apart -> Period_o=11, exactly one Valid_o per pulse.
- Missing strobe: no edge after an edge.
  - Timeout_o pulses 23 cycles after the edge cycle; Locked_o=0.
  - Next edge gives no Valid_o; the one after gives Period_o as measured.
  - Edge at exactly 22 instead -> Period_o=22, Late_o, no Timeout_o.
- Disable/reset mid-operation:
  - Enable_i=0 at count 5 -> no Valid_o, Locked_o=0, Period_o holds 11.
  - Re-enable: the first edge only arms.
  - Reset=0 mid-period -> all outputs 0 without waiting for a Clock edge.

Source files
------------

// File: rtl/strobe_monitor.sv
// strobe_monitor: measures the interval between rising edges of a strobe and
// classifies it against the expected period. It also reports lock and missing strobes.
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Enable_i   in   1 = monitor running, 0 = idle
//   Strobe_i   in   strobe synchronous to Clock, any high width
//   Period_o   out  last measured edge-to-edge interval in Clock cycles
//   Valid_o    out  one-cycle pulse: Period_o and flags just updated
//   Ok_o       out  last period within TICKS +/- TOLERANCE (held)
//   Early_o    out  last period below TICKS - TOLERANCE (held)
//   Late_o     out  last period above TICKS + TOLERANCE (held)
//   Timeout_o  out  one-cycle pulse: no edge within TIMEOUT cycles
//   Locked_o   out  LOCK_COUNT consecutive Ok periods seen
module strobe_monitor #(
    parameter real CLOCK_HZ   = 10_000_000.0,
    parameter int  PERIOD_NS  = 1000,
    parameter int  TOLERANCE  = 1,
    parameter int  LOCK_COUNT = 4,
    localparam int TICKS_RAW  = int'(CLOCK_HZ * PERIOD_NS / 1.0e9),
    localparam int TICKS      = (TICKS_RAW < 2) ? 2 : TICKS_RAW,
    localparam int TIMEOUT    = 2 * TICKS,
    localparam int WIDTH      = $clog2(TIMEOUT + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable_i,
    input  logic             Strobe_i,
    output logic [WIDTH-1:0] Period_o,
    output logic             Valid_o,
    output logic             Ok_o,
    output logic             Early_o,
    output logic             Late_o,
    output logic             Timeout_o,
    output logic             Locked_o
);
    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [LW-1:0] LOCK_W = LW'(LOCK_COUNT);

    state_t state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
    logic [LW-1:0] lock_q, lock_d;
    logic strobe_q, valid_q, valid_d, ok_q, ok_d, early_q, early_d;
    logic late_q, late_d, timeout_q, timeout_d, locked_q, locked_d;
    logic rise, early_w, late_w;

    // A multi-cycle high strobe produces a single rise.
    assign rise    = Strobe_i & ~strobe_q;
    // When an edge is seen, count_q is exactly the edge-to-edge interval.
    assign early_w = int'(count_q) < TICKS - TOLERANCE;
    assign late_w  = int'(count_q) > TICKS + TOLERANCE;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        lock_d    = lock_q;
        ok_d      = ok_q;
        early_d   = early_q;
        late_d    = late_q;
        locked_d  = locked_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (!Enable_i) begin
            state_d  = IDLE;
            count_d  = '0;
            lock_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    count_d = '0;
                end
                ARMED: begin
                    if (rise) begin
                        count_d = WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge coinciding with the timeout still counts as a measurement.
                    if (rise) begin
                        period_d = count_q;
                        valid_d  = 1'b1;
                        early_d  = early_w;
                        late_d   = late_w;
                        ok_d     = !early_w && !late_w;
                        count_d  = WIDTH'(1);
                        if (!early_w && !late_w) begin
                            lock_d   = (lock_q == LOCK_W) ? lock_q : lock_q + LW'(1);
                            locked_d = (lock_d == LOCK_W);
                        end else begin
                            lock_d   = '0;
                            locked_d = 1'b0;
                        end
                    end else if (count_q == TIMEOUT_W) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        lock_d    = '0;
                        count_d   = '0;
                        state_d   = ARMED;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            lock_q    <= '0;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
            ok_q      <= 1'b0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            lock_q    <= lock_d;
            strobe_q  <= Strobe_i;
            valid_q   <= valid_d;
            ok_q      <= ok_d;
            early_q   <= early_d;
            late_q    <= late_d;
            timeout_q <= timeout_d;
            locked_q  <= locked_d;
        end
    end

    assign Period_o  = period_q;
    assign Valid_o   = valid_q;
    assign Ok_o      = ok_q;
    assign Early_o   = early_q;
    assign Late_o    = late_q;
    assign Timeout_o = timeout_q;
    assign Locked_o  = locked_q;
endmodule

// File: tb/tb_strobe_monitor.sv
// tb_strobe_monitor: directed and random strobe sequences against a timestamp-based model of strobe_monitor.
module tb_strobe_monitor;
    localparam int TICKS   = 11;
    localparam int TOL     = 1;
    localparam int LC      = 4;
    localparam int TIMEOUT = 22;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable_i = 1'b0;
    logic       Strobe_i = 1'b0;
    logic [4:0] Period_o;
    logic       Valid_o, Ok_o, Early_o, Late_o, Timeout_o, Locked_o;

    strobe_monitor #(
        .CLOCK_HZ(11_000_000.0),
        .PERIOD_NS(1000),
        .TOLERANCE(TOL),
        .LOCK_COUNT(LC)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable_i(Enable_i),
        .Strobe_i(Strobe_i),
        .Period_o(Period_o),
        .Valid_o(Valid_o),
        .Ok_o(Ok_o),
        .Early_o(Early_o),
        .Late_o(Late_o),
        .Timeout_o(Timeout_o),
        .Locked_o(Locked_o)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    // Model state: timestamps of edges rather than a running counter.
    int cyc = 0;
    int last_edge = -1;
    int run = 0;
    bit m_idle = 1'b1;
    bit prev = 1'b0;
    int m_period = 0;
    bit m_valid = 0, m_ok = 0, m_early = 0, m_late = 0, m_timeout = 0, m_locked = 0;

    // Observations of the DUT used by the literal expectations.
    int vq_p[$];
    int vq_c[$];
    int vq_l[$];
    int n_timeout = 0;
    int last_valid_cyc = 0;
    int to_gap = -1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        int d;
        bit r;
        if (!Reset) begin
            m_idle = 1'b1; last_edge = -1; prev = 1'b0; run = 0;
            m_valid = 0; m_timeout = 0; m_period = 0;
            m_ok = 0; m_early = 0; m_late = 0; m_locked = 0;
        end else begin
            r = Strobe_i && !prev;
            prev = Strobe_i;
            m_valid = 0;
            m_timeout = 0;
            if (!Enable_i) begin
                m_idle = 1'b1; last_edge = -1; run = 0; m_locked = 0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (r) begin
                if (last_edge >= 0) begin
                    d = cyc - last_edge;
                    m_valid = 1;
                    m_period = d;
                    m_early = d < TICKS - TOL;
                    m_late = d > TICKS + TOL;
                    m_ok = !m_early && !m_late;
                    run = m_ok ? ((run + 1 > LC) ? LC : run + 1) : 0;
                    m_locked = (run == LC);
                end
                last_edge = cyc;
            end else if (last_edge >= 0 && cyc - last_edge == TIMEOUT) begin
                m_timeout = 1; m_locked = 0; run = 0; last_edge = -1;
            end
            cyc++;
        end
    endtask

    initial forever begin
        @(posedge Clock or negedge Reset);
        model_step();
    end

    initial forever begin
        @(negedge Clock);
        chk("valid", Valid_o, m_valid);
        chk("timeout", Timeout_o, m_timeout);
        chk("period", int'(Period_o), m_period);
        chk("ok", Ok_o, m_ok);
        chk("early", Early_o, m_early);
        chk("late", Late_o, m_late);
        chk("locked", Locked_o, m_locked);
        if (Valid_o) begin
            vq_p.push_back(int'(Period_o));
            vq_c.push_back(Late_o ? 2 : (Early_o ? 1 : 0));
            vq_l.push_back(int'(Locked_o));
            last_valid_cyc = cyc;
        end
        if (Timeout_o) begin
            n_timeout++;
            if (n_timeout == 1) to_gap = cyc - last_valid_cyc;
        end
    end

    // Rising edge now, next rising edge n cycles later; strobe high for w cycles.
    task automatic pulse_w(input int n, input int w);
        for (int i = 0; i < n; i++) begin
            Strobe_i = (i < w);
            @(negedge Clock);
        end
    endtask

    task automatic pulse(input int n);
        pulse_w(n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_p[22] = '{11, 11, 11, 11, 11, 11, 10, 12, 13, 9, 11, 11, 11, 11, 11, 14, 22, 11, 11, 11, 11, 11};
        int exp_c[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0};
        int exp_l[22] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        int n;
        repeat (3) @(negedge Clock);
        chk("rst_period", int'(Period_o), 0);
        chk("rst_locked", Locked_o, 0);
        Reset = 1'b1;
        @(negedge Clock);
        Enable_i = 1'b1;
        repeat (2) @(negedge Clock);
        repeat (6) pulse(11);
        chk("lockup_nvalid", vq_p.size(), 5);
        chk("lockup_locked", Locked_o, 1);
        pulse(10); pulse(12); pulse(13); pulse(9);
        repeat (4) pulse(11);
        repeat (2) pulse_w(11, 5);
        repeat (30) @(negedge Clock);
        chk("timeout_gap", to_gap, 22);
        chk("timeout_locked", Locked_o, 0);
        pulse(14); pulse(22); pulse(11);
        repeat (3) pulse(11);
        pulse(5);
        Enable_i = 1'b0;
        Strobe_i = 1'b1;
        @(negedge Clock);
        Strobe_i = 1'b0;
        repeat (5) @(negedge Clock);
        chk("dis_locked", Locked_o, 0);
        chk("dis_period", int'(Period_o), 11);
        chk("dis_nvalid", vq_p.size(), 21);
        chk("n_timeout", n_timeout, 1);
        Enable_i = 1'b1;
        repeat (2) @(negedge Clock);
        pulse(11);
        Strobe_i = 1'b1;
        @(negedge Clock);
        Strobe_i = 1'b0;
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("async_period", int'(Period_o), 0);
        chk("async_valid", Valid_o, 0);
        chk("async_ok", Ok_o, 0);
        chk("async_early", Early_o, 0);
        chk("async_late", Late_o, 0);
        chk("async_timeout", Timeout_o, 0);
        chk("async_locked", Locked_o, 0);
        chk("seq_len", vq_p.size(), 22);
        for (int i = 0; i < 22; i++) begin
            if (i < vq_p.size()) begin
                chk($sformatf("seq_period[%0d]", i), vq_p[i], exp_p[i]);
                chk($sformatf("seq_class[%0d]", i), vq_c[i], exp_c[i]);
                chk($sformatf("seq_locked[%0d]", i), vq_l[i], exp_l[i]);
            end
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                Enable_i = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    Strobe_i = 1'($urandom_range(0, 1));
                    @(negedge Clock);
                end
                Enable_i = 1'b1;
            end else begin
                n = $urandom_range(2, 30);
                pulse_w(n, $urandom_range(1, n - 1));
            end
        end
        repeat (3) @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
